// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: ALU control codes, opcodes and the issue-stage payload.
// Immediate extraction helpers are shared by the decoder.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_SLT = 4'd5;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef struct packed {
    logic [3:0]      alu_ctl;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] store_data;
    logic [4:0]      rd;
    logic            we;
    logic            illegal;
  } issue_t;

  function automatic logic [XLEN-1:0] imm_i(input logic [31:0] instr);
    return {{(XLEN-12){instr[31]}}, instr[31:20]};
  endfunction

  function automatic logic [XLEN-1:0] imm_s(input logic [31:0] instr);
    return {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
  endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational decoder from instruction word and register read data to an ALU issue payload.
// Anything the ALU cannot execute yields an illegal, side-effect-free payload.
module alu_decode
  import riscv_pkg::*;
(
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output issue_t          issue
);

  logic [6:0] opcode_s;
  logic [2:0] funct3_s;
  logic [6:0] funct7_s;
  logic [4:0] rd_s;
  logic [3:0] f3_ctl_s;
  logic       f3_ok_s;

  assign opcode_s = instr[6:0];
  assign funct3_s = instr[14:12];
  assign funct7_s = instr[31:25];
  assign rd_s     = instr[11:7];

  // Shared funct3 map for OP and OP-IMM; shifts and SLTU are not supported
  always_comb begin
    f3_ctl_s = ALU_ADD;
    f3_ok_s  = 1'b1;
    case (funct3_s)
      3'b000:  f3_ctl_s = ALU_ADD;
      3'b100:  f3_ctl_s = ALU_XOR;
      3'b110:  f3_ctl_s = ALU_OR;
      3'b111:  f3_ctl_s = ALU_AND;
      3'b010:  f3_ctl_s = ALU_SLT;
      default: f3_ok_s  = 1'b0;
    endcase
  end

  // Main decode; illegal payload is the default and legal cases overwrite it
  always_comb begin
    issue         = '0;
    issue.alu_ctl = ALU_ADD;
    issue.illegal = 1'b1;
    case (opcode_s)
      OPC_OP: begin
        if (funct7_s == 7'h00 && f3_ok_s) begin
          issue.alu_ctl = f3_ctl_s;
          issue.illegal = 1'b0;
        end else if (funct7_s == 7'h20 && funct3_s == 3'b000) begin
          issue.alu_ctl = ALU_SUB;
          issue.illegal = 1'b0;
        end else begin
          issue.illegal = 1'b1;
        end
        if (!issue.illegal) begin
          issue.a  = rs1_data;
          issue.b  = rs2_data;
          issue.rd = rd_s;
          issue.we = (rd_s != 5'd0);
        end else begin
          issue.we = 1'b0;
        end
      end
      OPC_OP_IMM: begin
        if (f3_ok_s) begin
          issue.alu_ctl = f3_ctl_s;
          issue.illegal = 1'b0;
          issue.a       = rs1_data;
          issue.b       = imm_i(instr);
          issue.rd      = rd_s;
          issue.we      = (rd_s != 5'd0);
        end else begin
          issue.illegal = 1'b1;
        end
      end
      OPC_LOAD: begin
        issue.illegal = 1'b0;
        issue.a       = rs1_data;
        issue.b       = imm_i(instr);
        issue.rd      = rd_s;
        issue.we      = (rd_s != 5'd0);
      end
      OPC_STORE: begin
        issue.illegal    = 1'b0;
        issue.a          = rs1_data;
        issue.b          = imm_s(instr);
        issue.store_data = rs2_data;
      end
      OPC_BRANCH: begin
        if (funct3_s == 3'b000 || funct3_s == 3'b001) begin
          issue.alu_ctl = ALU_SUB;
          issue.illegal = 1'b0;
          issue.a       = rs1_data;
          issue.b       = rs2_data;
        end else begin
          issue.illegal = 1'b1;
        end
      end
      default: issue.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Decode/issue stage: decodes an instruction and holds the result in an output register
// backed by a one-entry skid register, with valid/ready on both sides and a flush.
module alu_issue_stage
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_instr,
  input  logic [DATA_WIDTH-1:0] in_rs1_data,
  input  logic [DATA_WIDTH-1:0] in_rs2_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [3:0]            out_alu_ctl,
  output logic [DATA_WIDTH-1:0] out_a,
  output logic [DATA_WIDTH-1:0] out_b,
  output logic [DATA_WIDTH-1:0] out_store_data,
  output logic [4:0]            out_rd,
  output logic                  out_we,
  output logic                  out_illegal
);

  issue_t dec_s;
  issue_t out_r;
  issue_t skid_r;
  logic   out_valid_r;
  logic   skid_valid_r;
  logic   accept_s;
  logic   out_free_s;

  alu_decode u_decode (
    .instr    (in_instr),
    .rs1_data (in_rs1_data),
    .rs2_data (in_rs2_data),
    .issue    (dec_s)
  );

  // in_ready depends only on skid occupancy, never combinationally on out_ready
  assign in_ready   = !skid_valid_r;
  assign accept_s   = in_valid && !skid_valid_r;
  assign out_free_s = !out_valid_r || out_ready;

  // Output/skid occupancy and payload; flush and reset dominate every other event
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      out_r        <= '0;
      skid_r       <= '0;
      out_valid_r  <= 1'b0;
      skid_valid_r <= 1'b0;
    end else if (out_free_s) begin
      if (skid_valid_r) begin
        out_r        <= skid_r;
        out_valid_r  <= 1'b1;
        skid_valid_r <= 1'b0;
      end else if (accept_s) begin
        out_r       <= dec_s;
        out_valid_r <= 1'b1;
      end else begin
        out_valid_r <= 1'b0;
      end
    end else if (accept_s) begin
      skid_r       <= dec_s;
      skid_valid_r <= 1'b1;
    end else begin
      skid_valid_r <= skid_valid_r;
    end
  end

  assign out_valid      = out_valid_r;
  assign out_alu_ctl    = out_r.alu_ctl;
  assign out_a          = out_r.a;
  assign out_b          = out_r.b;
  assign out_store_data = out_r.store_data;
  assign out_rd         = out_r.rd;
  assign out_we         = out_r.we;
  assign out_illegal    = out_r.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed self-checking bench for alu_issue_stage: decode vectors, backpressure,
// flush and reset behaviour, with hand-computed expectations.
module tb_alu_issue_stage;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, in_rs1_data, in_rs2_data;
  logic [3:0]  out_alu_ctl;
  logic [31:0] out_a, out_b, out_store_data;
  logic [4:0]  out_rd;
  logic        out_we, out_illegal;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_issue_stage #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_alu_ctl(out_alu_ctl),
    .out_a(out_a), .out_b(out_b), .out_store_data(out_store_data),
    .out_rd(out_rd), .out_we(out_we), .out_illegal(out_illegal)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] r1,
                       input logic [31:0] r2);
    in_valid    = v;
    in_instr    = ins;
    in_rs1_data = r1;
    in_rs2_data = r2;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_valid"},   {31'd0, out_valid},   32'd0);
    check({tag, "_inready"}, {31'd0, in_ready},    32'd1);
    check({tag, "_ctl"},     {28'd0, out_alu_ctl}, {28'd0, ALU_ADD});
    check({tag, "_ill"},     {31'd0, out_illegal}, 32'd0);
    check({tag, "_we"},      {31'd0, out_we},      32'd0);
    check({tag, "_a"},       out_a,                32'd0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b1, 32'h002081B3, 32'd1, 32'd1);
    tick(); tick();
    check_reset_state("reset");
    rst = 1'b0;

    // Streaming decode with out_ready held high
    out_ready = 1'b1;
    drive(1'b1, 32'h002081B3, 32'd5, 32'd7); tick();
    check("add_valid", {31'd0, out_valid}, 32'd1);
    check("add_ctl", {28'd0, out_alu_ctl}, {28'd0, ALU_ADD});
    check("add_a", out_a, 32'd5);
    check("add_b", out_b, 32'd7);
    check("add_rd", {27'd0, out_rd}, 32'd3);
    check("add_we", {31'd0, out_we}, 32'd1);
    check("add_ill", {31'd0, out_illegal}, 32'd0);

    drive(1'b1, 32'h402081B3, 32'd10, 32'd3); tick();
    check("sub_ctl", {28'd0, out_alu_ctl}, {28'd0, ALU_SUB});
    check("sub_a", out_a, 32'd10);
    check("sub_b", out_b, 32'd3);

    drive(1'b1, 32'h0020A1B3, 32'd4, 32'd9); tick();
    check("slt_ctl", {28'd0, out_alu_ctl}, {28'd0, ALU_SLT});

    drive(1'b1, 32'hFFF00293, 32'd0, 32'd77); tick();
    check("addi_ctl", {28'd0, out_alu_ctl}, {28'd0, ALU_ADD});
    check("addi_a", out_a, 32'd0);
    check("addi_b", out_b, 32'hFFFF_FFFF);
    check("addi_rd", {27'd0, out_rd}, 32'd5);
    check("addi_we", {31'd0, out_we}, 32'd1);

    drive(1'b1, 32'h0000_0000, 32'd9, 32'd9); tick();
    check("zero_ill", {31'd0, out_illegal}, 32'd1);
    check("zero_we", {31'd0, out_we}, 32'd0);
    check("zero_ctl", {28'd0, out_alu_ctl}, {28'd0, ALU_ADD});
    check("zero_a", out_a, 32'd0);
    check("zero_b", out_b, 32'd0);

    drive(1'b1, 32'h0F00F213, 32'h1234, 32'd0); tick();
    check("andi_ctl", {28'd0, out_alu_ctl}, {28'd0, ALU_AND});
    check("andi_b", out_b, 32'h0000_00F0);
    check("andi_rd", {27'd0, out_rd}, 32'd4);

    drive(1'b1, 32'hFFC0A303, 32'h1000, 32'd5); tick();
    check("lw_a", out_a, 32'h1000);
    check("lw_b", out_b, 32'hFFFF_FFFC);
    check("lw_we", {31'd0, out_we}, 32'd1);
    check("lw_sd", out_store_data, 32'd0);

    drive(1'b1, 32'h0020A423, 32'h100, 32'hAB); tick();
    check("sw_ctl", {28'd0, out_alu_ctl}, {28'd0, ALU_ADD});
    check("sw_b", out_b, 32'd8);
    check("sw_sd", out_store_data, 32'hAB);
    check("sw_we", {31'd0, out_we}, 32'd0);
    check("sw_ill", {31'd0, out_illegal}, 32'd0);

    drive(1'b1, 32'h00208463, 32'd20, 32'd6); tick();
    check("beq_ctl", {28'd0, out_alu_ctl}, {28'd0, ALU_SUB});
    check("beq_b", out_b, 32'd6);
    check("beq_we", {31'd0, out_we}, 32'd0);

    drive(1'b1, 32'h00109093, 32'd3, 32'd3); tick();
    check("slli_ill", {31'd0, out_illegal}, 32'd1);
    check("slli_a", out_a, 32'd0);

    drive(1'b1, 32'h0020B1B3, 32'd3, 32'd3); tick();
    check("sltu_ill", {31'd0, out_illegal}, 32'd1);

    drive(1'b1, 32'h00208033, 32'd3, 32'd4); tick();
    check("rd0_ill", {31'd0, out_illegal}, 32'd0);
    check("rd0_we", {31'd0, out_we}, 32'd0);

    drive(1'b0, 32'h0, 32'd0, 32'd0); tick();
    check("drained_valid", {31'd0, out_valid}, 32'd0);

    // Backpressure: A, B, C back to back with out_ready low
    out_ready = 1'b0;
    drive(1'b1, 32'h002081B3, 32'd1, 32'd0); tick();
    check("bp1_valid", {31'd0, out_valid}, 32'd1);
    check("bp1_a", out_a, 32'd1);
    check("bp1_inready", {31'd0, in_ready}, 32'd1);
    drive(1'b1, 32'h002081B3, 32'd2, 32'd0); tick();
    check("bp2_a", out_a, 32'd1);
    check("bp2_inready", {31'd0, in_ready}, 32'd0);
    drive(1'b1, 32'h002081B3, 32'd3, 32'd0); tick();
    check("bp3_a", out_a, 32'd1);
    check("bp3_inready", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1; tick();
    check("bp4_a", out_a, 32'd2);
    check("bp4_valid", {31'd0, out_valid}, 32'd1);
    check("bp4_inready", {31'd0, in_ready}, 32'd1);
    tick();
    check("bp5_a", out_a, 32'd3);
    check("bp5_valid", {31'd0, out_valid}, 32'd1);
    drive(1'b0, 32'h0, 32'd0, 32'd0); tick();
    check("bp6_valid", {31'd0, out_valid}, 32'd0);

    // Flush with both entries full and a beat on the input
    out_ready = 1'b0;
    drive(1'b1, 32'h002081B3, 32'h11, 32'd0); tick();
    drive(1'b1, 32'h002081B3, 32'h22, 32'd0); tick();
    check("fl_full_inready", {31'd0, in_ready}, 32'd0);
    drive(1'b1, 32'h002081B3, 32'h33, 32'd0);
    flush = 1'b1; tick();
    flush = 1'b0;
    check_reset_state("flush");
    drive(1'b0, 32'h0, 32'd0, 32'd0);
    out_ready = 1'b1; tick();
    check("fl_post1_valid", {31'd0, out_valid}, 32'd0);
    tick();
    check("fl_post2_valid", {31'd0, out_valid}, 32'd0);

    // Reset mid-stall, then a fresh beat with one-cycle latency
    out_ready = 1'b0;
    drive(1'b1, 32'h002081B3, 32'h55, 32'd1); tick();
    drive(1'b1, 32'h002081B3, 32'h66, 32'd1); tick();
    rst = 1'b1; tick();
    check_reset_state("midrst");
    rst = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 32'h002081B3, 32'h44, 32'd2); tick();
    check("postrst_valid", {31'd0, out_valid}, 32'd1);
    check("postrst_a", out_a, 32'h44);
    drive(1'b0, 32'h0, 32'd0, 32'd0); tick();
    check("postrst_drain", {31'd0, out_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
